// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write queue slice.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_match.sv
// wq_match: per-read-port lookup over the queued writes, youngest match wins.
// The data output exists only when REGFILE_WRITE_QUEUE_BYPASS_EN is defined.
module wq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_ADDR_W-1:0]        dests [DEPTH],
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    input  logic [DATA_W-1:0]            datas [DEPTH],
`endif
    input  logic [$clog2(DEPTH)-1:0]     headPtr,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [REG_ADDR_W-1:0]        readAddr,
    output logic                         hit
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    ,
    output logic [DATA_W-1:0]            data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Walk from oldest to youngest so the last assignment (the youngest match) sticks.
    always_comb begin
        hit = 1'b0;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && (readAddr != REG_ZERO) &&
                (dests[headPtr + PW'(k)] == readAddr)) begin
                hit = 1'b1;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
                data = datas[headPtr + PW'(k)];
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Two-producer (ALU, load) write queue in front of the single register-file write port.
// Define REGFILE_WRITE_QUEUE_BYPASS_EN to add BypassData1/BypassData2 forwarding outputs.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          AluValid,
    output logic                          AluReady,
    input  logic [REG_ADDR_W-1:0]         AluDest,
    input  logic [DATA_W-1:0]             AluData,
    input  logic                          LdValid,
    output logic                          LdReady,
    input  logic [REG_ADDR_W-1:0]         LdDest,
    input  logic [DATA_W-1:0]             LdData,
    output logic                          RegWrite,
    output logic [REG_ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]             WriteData,
    input  logic [REG_ADDR_W-1:0]         ReadRegister1,
    input  logic [REG_ADDR_W-1:0]         ReadRegister2,
    output logic                          Pending1,
    output logic                          Pending2,
    output logic [$clog2(DEPTH+1)-1:0]    Count
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    ,
    output logic [DATA_W-1:0]             BypassData1,
    output logic [DATA_W-1:0]             BypassData2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wq_entry_t             entries [DEPTH];
    wq_entry_t             lastEntry;
    logic [PW-1:0]         headPtr;
    logic [PW-1:0]         tailPtr;
    logic [PW-1:0]         aluSlot;
    logic                  ldEnq;
    logic                  aluEnq;
    logic                  deq;
    logic [REG_ADDR_W-1:0] dests [DEPTH];
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    logic [DATA_W-1:0]     datas [DEPTH];
`endif

    // Handshake: a producer transfers on a cycle where Valid and Ready are both high at the
    // posedge. Ready looks only at the registered Count (never at this cycle's drain), so
    // it can drop while Valid is held; the producer keeps Dest/Data stable until it transfers.
    assign LdReady  = (Count != CW'(DEPTH));
    assign AluReady = (Count <= CW'(DEPTH-2)) || ((Count == CW'(DEPTH-1)) && !LdValid);

    // $0 writes still complete the handshake but never occupy a slot.
    assign ldEnq   = LdValid && LdReady && (LdDest != REG_ZERO);
    assign aluEnq  = AluValid && AluReady && (AluDest != REG_ZERO);
    assign deq     = (Count != '0);
    assign aluSlot = tailPtr + PW'(ldEnq);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            lastEntry <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
            Count     <= '0;
        end else begin
            // The load is the older instruction, so it takes the tail slot first.
            if (ldEnq)  entries[tailPtr] <= '{dest: LdDest, data: LdData};
            if (aluEnq) entries[aluSlot] <= '{dest: AluDest, data: AluData};
            if (deq)    lastEntry <= entries[headPtr];
            tailPtr <= tailPtr + PW'(ldEnq) + PW'(aluEnq);
            headPtr <= headPtr + PW'(deq);
            Count   <= Count + CW'(ldEnq) + CW'(aluEnq) - CW'(deq);
        end
    end

    assign RegWrite      = deq;
    assign WriteRegister = deq ? entries[headPtr].dest : lastEntry.dest;
    assign WriteData     = deq ? entries[headPtr].data : lastEntry.data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dests[i] = entries[i].dest;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
            datas[i] = entries[i].data;
`endif
        end
    end

    wq_match #(.DEPTH(DEPTH)) uMatch1 (
        .dests    (dests),
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .datas    (datas),
`endif
        .headPtr  (headPtr),
        .count    (Count),
        .readAddr (ReadRegister1),
        .hit      (Pending1)
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        ,
        .data     (BypassData1)
`endif
    );

    wq_match #(.DEPTH(DEPTH)) uMatch2 (
        .dests    (dests),
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .datas    (datas),
`endif
        .headPtr  (headPtr),
        .count    (Count),
        .readAddr (ReadRegister2),
        .hit      (Pending2)
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        ,
        .data     (BypassData2)
`endif
    );

endmodule
